// File: rtl/zbuf_depth_writer.sv
// Depth-tested pixel writer with a 1-entry input holding register.
// Each pixel is read, compared and conditionally written before the next one
// is read, so depth updates are visible to back-to-back pixels at the same
// address. A clear fills the depth buffer with 16'hFFFF, one word per cycle.
module zbuf_depth_writer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int AW    = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          plot,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic [15:0]   z_in,
    input  logic [7:0]    color,
    input  logic          clear,
    output logic [AW-1:0] zb_addr,
    output logic          zb_rd,
    input  logic [15:0]   zb_rdata,
    output logic          zb_we,
    output logic [15:0]   zb_wdata,
    output logic [AW-1:0] fb_addr,
    output logic          fb_we,
    output logic [7:0]    fb_data,
    output logic          busy,
    output logic          overflow,
    output logic [15:0]   pix_written,
    output logic [15:0]   pix_rejected
);

    typedef enum logic [2:0] {IDLE, CLEAR, RD, CMP, WR} state_t;

    localparam logic [AW-1:0] CLR_LAST = AW'(H_RES * V_RES - 1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    state_t        state_q;

    // holding register
    logic          hold_full_q;
    logic [10:0]   hx_q, hy_q;
    logic [15:0]   hz_q;
    logic [7:0]    hc_q;

    // pixel in flight
    logic [AW-1:0] pa_q;
    logic [15:0]   pz_q;
    logic [7:0]    pc_q;

    logic          clr_pend_q;
    logic [AW-1:0] clr_addr_q;
    logic          overflow_q;
    logic [15:0]   written_q, rejected_q;

    logic [AW-1:0] zb_addr_q, fb_addr_q;
    logic          zb_rd_q, zb_we_q, fb_we_q;
    logic [15:0]   zb_wdata_q;
    logic [7:0]    fb_data_q;

    logic          clr_go_d, oor_d, idle_reject_d, hold_pop_d, hold_push_d, drop_d;
    logic [AW-1:0] pix_addr_d;

    // Hold-register handshake and address of the held pixel
    always_comb begin
        clr_go_d      = clear | clr_pend_q;
        oor_d         = (32'(hx_q) >= 32'(H_RES)) || (32'(hy_q) >= 32'(V_RES));
        pix_addr_d    = AW'(32'(hy_q) * 32'(H_RES) + 32'(hx_q));
        idle_reject_d = (state_q == IDLE) && hold_full_q && !clr_go_d && oor_d;
        hold_pop_d    = (state_q == RD) || idle_reject_d;
        hold_push_d   = plot && (!hold_full_q || hold_pop_d);
        drop_d        = plot && hold_full_q && !hold_pop_d;
    end

    // Holding register capture/empty and sticky overflow on a dropped plot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_full_q <= 1'b0;
            hx_q        <= '0;
            hy_q        <= '0;
            hz_q        <= '0;
            hc_q        <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (hold_push_d) begin
                hold_full_q <= 1'b1;
                hx_q        <= x;
                hy_q        <= y;
                hz_q        <= z_in;
                hc_q        <= color;
            end else if (hold_pop_d) begin
                hold_full_q <= 1'b0;
            end
            if (drop_d) overflow_q <= 1'b1;
        end
    end

    // Main FSM with registered memory strobes, pending clear and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            clr_pend_q <= 1'b0;
            clr_addr_q <= '0;
            pa_q       <= '0;
            pz_q       <= '0;
            pc_q       <= '0;
            written_q  <= '0;
            rejected_q <= '0;
            zb_addr_q  <= '0;
            fb_addr_q  <= '0;
            zb_rd_q    <= 1'b0;
            zb_we_q    <= 1'b0;
            fb_we_q    <= 1'b0;
            zb_wdata_q <= '0;
            fb_data_q  <= '0;
        end else begin
            // strobes and buses are zero unless set below
            zb_rd_q    <= 1'b0;
            zb_we_q    <= 1'b0;
            fb_we_q    <= 1'b0;
            zb_addr_q  <= '0;
            fb_addr_q  <= '0;
            zb_wdata_q <= '0;
            fb_data_q  <= '0;

            // clears seen while busy merge into one pending clear
            if (state_q != IDLE && clear) clr_pend_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (clr_go_d) begin
                        clr_pend_q <= 1'b0;
                        clr_addr_q <= '0;
                        zb_we_q    <= 1'b1;
                        zb_addr_q  <= '0;
                        zb_wdata_q <= 16'hFFFF;
                        state_q    <= CLEAR;
                    end else if (hold_full_q) begin
                        if (oor_d) begin
                            if (rejected_q != 16'hFFFF) rejected_q <= rejected_q + 16'd1;
                        end else begin
                            pa_q      <= pix_addr_d;
                            pz_q      <= hz_q;
                            pc_q      <= hc_q;
                            zb_rd_q   <= 1'b1;
                            zb_addr_q <= pix_addr_d;
                            state_q   <= RD;
                        end
                    end
                end
                CLEAR: begin
                    if (clr_addr_q == CLR_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        clr_addr_q <= clr_addr_q + ADDR_ONE;
                        zb_we_q    <= 1'b1;
                        zb_addr_q  <= clr_addr_q + ADDR_ONE;
                        zb_wdata_q <= 16'hFFFF;
                    end
                end
                RD: state_q <= CMP;
                CMP: begin
                    // strictly closer wins; equal depth is rejected
                    if (pz_q < zb_rdata) begin
                        zb_we_q    <= 1'b1;
                        fb_we_q    <= 1'b1;
                        zb_addr_q  <= pa_q;
                        fb_addr_q  <= pa_q;
                        zb_wdata_q <= pz_q;
                        fb_data_q  <= pc_q;
                        if (written_q != 16'hFFFF) written_q <= written_q + 16'd1;
                        state_q    <= WR;
                    end else begin
                        if (rejected_q != 16'hFFFF) rejected_q <= rejected_q + 16'd1;
                        state_q <= IDLE;
                    end
                end
                WR:      state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign zb_addr      = zb_addr_q;
    assign zb_rd        = zb_rd_q;
    assign zb_we        = zb_we_q;
    assign zb_wdata     = zb_wdata_q;
    assign fb_addr      = fb_addr_q;
    assign fb_we        = fb_we_q;
    assign fb_data      = fb_data_q;
    assign busy         = (state_q != IDLE) || hold_full_q;
    assign overflow     = overflow_q;
    assign pix_written  = written_q;
    assign pix_rejected = rejected_q;

endmodule

// File: tb/tb_zbuf_depth_writer.sv
// Bench for zbuf_depth_writer: directed scenarios plus random plots/clears,
// checked every cycle against a timeline model that schedules the expected
// memory strobes and counter updates for each accepted job.
module tb_zbuf_depth_writer;

    localparam int H = 4;
    localparam int V = 2;
    localparam int AW = 3;
    localparam int NMEM = 1 << AW;
    localparam int NPIX = H * V;
    localparam int SL = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          plot = 1'b0;
    logic [10:0]   x = '0, y = '0;
    logic [15:0]   z_in = '0;
    logic [7:0]    color = '0;
    logic          clear = 1'b0;
    logic [AW-1:0] zb_addr, fb_addr;
    logic          zb_rd, zb_we, fb_we, busy, overflow;
    logic [15:0]   zb_rdata = '0;
    logic [15:0]   zb_wdata, pix_written, pix_rejected;
    logic [7:0]    fb_data;

    zbuf_depth_writer #(.H_RES(H), .V_RES(V), .AW(AW)) dut (
        .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .z_in(z_in),
        .color(color), .clear(clear), .zb_addr(zb_addr), .zb_rd(zb_rd),
        .zb_rdata(zb_rdata), .zb_we(zb_we), .zb_wdata(zb_wdata),
        .fb_addr(fb_addr), .fb_we(fb_we), .fb_data(fb_data), .busy(busy),
        .overflow(overflow), .pix_written(pix_written), .pix_rejected(pix_rejected)
    );

    always #5 clk = ~clk;

    // external depth and frame memories
    logic [15:0] emem [NMEM];
    logic [7:0]  fmem [NMEM];
    always @(posedge clk) begin
        if (zb_we) emem[zb_addr] <= zb_wdata;
        if (fb_we) fmem[fb_addr] <= fb_data;
        if (zb_rd) zb_rdata <= emem[zb_addr];
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- timeline model ----------------
    bit          s_rd [SL], s_we [SL], s_fwe [SL], s_ovf [SL];
    int          s_addr [SL], s_incw [SL], s_incr [SL];
    logic [15:0] s_wd [SL];
    logic [7:0]  s_fd [SL];

    bit          m_hfull, m_pend, m_ovf;
    int          m_hx, m_hy, m_hempty_at, m_idle_from, m_w, m_r;
    logic [15:0] m_hz;
    logic [7:0]  m_hc;
    logic [15:0] m_mem [NMEM];

    task automatic clr_slot(input int k);
        s_rd[k] = 0; s_we[k] = 0; s_fwe[k] = 0; s_ovf[k] = 0;
        s_addr[k] = 0; s_incw[k] = 0; s_incr[k] = 0; s_wd[k] = 0; s_fd[k] = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < SL; i++) clr_slot(i);
        m_hfull = 0; m_pend = 0; m_ovf = 0; m_hempty_at = -1;
        m_idle_from = 0; m_w = 0; m_r = 0;
    endtask

    // compare process: one check set per cycle, then schedule from this cycle's inputs
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                model_reset();
                chk("rst_zb_rd", 32'(zb_rd), 0);
                chk("rst_zb_we", 32'(zb_we), 0);
                chk("rst_fb_we", 32'(fb_we), 0);
                chk("rst_addr", {29'b0, zb_addr} | {29'b0, fb_addr}, 0);
                chk("rst_data", {16'b0, zb_wdata} | {24'b0, fb_data}, 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_ovf", 32'(overflow), 0);
                chk("rst_cnt", {pix_written, pix_rejected}, 0);
                continue;
            end
            begin
                int  k;
                bit  emptying;
                k = cyc % SL;
                if (s_incw[k] != 0 && m_w < 65535) m_w++;
                if (s_incr[k] != 0 && m_r < 65535) m_r++;
                if (s_ovf[k]) m_ovf = 1;

                chk("zb_rd", 32'(zb_rd), 32'(s_rd[k]));
                chk("zb_we", 32'(zb_we), 32'(s_we[k]));
                chk("fb_we", 32'(fb_we), 32'(s_fwe[k]));
                if (s_rd[k] || s_we[k]) chk("zb_addr", 32'(zb_addr), s_addr[k]);
                if (s_we[k])  chk("zb_wdata", 32'(zb_wdata), 32'(s_wd[k]));
                if (s_fwe[k]) chk("fb_addr", 32'(fb_addr), s_addr[k]);
                if (s_fwe[k]) chk("fb_data", 32'(fb_data), 32'(s_fd[k]));
                chk("busy", 32'(busy), 32'((cyc < m_idle_from) || m_hfull));
                chk("overflow", 32'(overflow), 32'(m_ovf));
                chk("pix_written", 32'(pix_written), m_w);
                chk("pix_rejected", 32'(pix_rejected), m_r);
                clr_slot(k);

                emptying = m_hfull && (m_hempty_at == cyc);
                if (cyc >= m_idle_from) begin
                    if (clear || m_pend) begin
                        m_pend = 0;
                        for (int i = 0; i < NPIX; i++) begin
                            s_we[(cyc + 1 + i) % SL]   = 1;
                            s_addr[(cyc + 1 + i) % SL] = i;
                            s_wd[(cyc + 1 + i) % SL]   = 16'hFFFF;
                        end
                        for (int i = 0; i < NMEM; i++) m_mem[i] = 16'hFFFF;
                        m_idle_from = cyc + NPIX + 1;
                    end else if (m_hfull) begin
                        if (m_hx >= H || m_hy >= V) begin
                            emptying = 1;
                            s_incr[(cyc + 1) % SL] = 1;
                        end else begin
                            int a;
                            a = (m_hy * H + m_hx) % NMEM;
                            s_rd[(cyc + 1) % SL]   = 1;
                            s_addr[(cyc + 1) % SL] = a;
                            m_hempty_at = cyc + 1;
                            if (m_hz < m_mem[a]) begin
                                s_we[(cyc + 3) % SL]   = 1;
                                s_fwe[(cyc + 3) % SL]  = 1;
                                s_addr[(cyc + 3) % SL] = a;
                                s_wd[(cyc + 3) % SL]   = m_hz;
                                s_fd[(cyc + 3) % SL]   = m_hc;
                                s_incw[(cyc + 3) % SL] = 1;
                                m_mem[a] = m_hz;
                                m_idle_from = cyc + 4;
                            end else begin
                                s_incr[(cyc + 3) % SL] = 1;
                                m_idle_from = cyc + 3;
                            end
                        end
                    end
                end else if (clear) begin
                    m_pend = 1;
                end

                if (plot) begin
                    if (!m_hfull || emptying) begin
                        m_hfull = 1; m_hempty_at = -1;
                        m_hx = int'(x); m_hy = int'(y); m_hz = z_in; m_hc = color;
                    end else begin
                        s_ovf[(cyc + 1) % SL] = 1;
                    end
                end else if (emptying) begin
                    m_hfull = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic plot_px(input int px, input int py, input int pz, input int pc);
        plot = 1'b1; x = 11'(px); y = 11'(py); z_in = 16'(pz); color = 8'(pc);
        step();
        plot = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        chk("lit_rst_busy", 32'(busy), 0);
        reset = 1'b1;
        repeat (2) step();

        // full clear: 8 writes then idle
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("lit_clr_busy", 32'(busy), 1);
        repeat (8) step();
        chk("lit_clr_done", 32'(busy), 0);
        for (int i = 0; i < NMEM; i++) chk("lit_clr_mem", 32'(emem[i]), 32'hFFFF);

        // first pixel: read at N+2, write at N+4
        plot_px(1, 1, 16'h0100, 8'h5A);
        step();
        chk("lit_rd_strobe", {31'b0, zb_rd}, 1);
        chk("lit_rd_addr", 32'(zb_addr), 5);
        step(); step();
        chk("lit_wr_strobes", {30'b0, zb_we, fb_we}, 3);
        chk("lit_wr_addr", {13'b0, zb_addr, 13'b0, fb_addr}, {16'd5, 16'd5});
        chk("lit_wr_data", {8'b0, zb_wdata, fb_data}, 32'h0001005A);
        step();
        chk("lit_written1", 32'(pix_written), 1);
        repeat (3) step();

        // equal and farther depth both rejected
        plot_px(1, 1, 16'h0100, 8'h11);
        repeat (6) step();
        plot_px(1, 1, 16'h0200, 8'h22);
        repeat (6) step();
        chk("lit_rej2", 32'(pix_rejected), 2);
        chk("lit_wr_still1", 32'(pix_written), 1);

        // clipped pixel
        plot_px(4, 0, 16'h0001, 8'h33);
        repeat (3) step();
        chk("lit_rej3", 32'(pix_rejected), 3);

        // two accepted, third dropped
        plot_px(0, 0, 16'h0010, 8'h11);
        step();
        plot_px(2, 1, 16'h0020, 8'h22);
        step();
        plot_px(3, 1, 16'h0030, 8'h33);
        repeat (10) step();
        chk("lit_ovf", 32'(overflow), 1);
        chk("lit_written3", 32'(pix_written), 3);
        chk("lit_mem0", 32'(emem[0]), 32'h0010);
        chk("lit_mem6", 32'(emem[6]), 32'h0020);
        chk("lit_mem7", 32'(emem[7]), 32'hFFFF);

        // clear and plot together: clear first, then the pixel
        clear = 1'b1;
        plot_px(3, 0, 16'h0300, 8'h77);
        clear = 1'b0;
        repeat (16) step();
        chk("lit_cp_mem3", 32'(emem[3]), 32'h0300);
        chk("lit_cp_fb3", 32'(fmem[3]), 32'h77);
        chk("lit_cp_mem0", 32'(emem[0]), 32'hFFFF);
        chk("lit_written4", 32'(pix_written), 4);

        // reset mid-clear: everything drops to zero at once
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("lit_mid_rst_strobes", {29'b0, zb_rd, zb_we, fb_we}, 0);
        chk("lit_mid_rst_bus", {13'b0, zb_addr, zb_wdata}, 0);
        chk("lit_mid_rst_stat", {14'b0, busy, overflow, pix_written}, 0);
        repeat (2) step();
        reset = 1'b1;
        step();

        // random traffic, starting from a cleared buffer
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (10) step();
        for (int i = 0; i < 2500; i++) begin
            plot  = ($urandom_range(0, 2) == 0);
            x     = 11'($urandom_range(0, 4));
            y     = 11'($urandom_range(0, 2));
            z_in  = 16'($urandom_range(0, 4095));
            color = 8'($urandom);
            clear = ($urandom_range(0, 59) == 0);
            step();
        end
        plot = 1'b0;
        clear = 1'b0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
